// File: rtl/frogger_game_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : frogger_game_ctrl_if
//  Description : Signal bundle between the Frogger game controller and the
//                board side (buttons, car-row datapath, VGA draw logic).
//                Optional macro FROGGER_TIMER_EN adds the time_left signal.
//  Revision    : 1.0 - initial release
// ============================================================================
interface frogger_game_ctrl_if;
    logic       up_n;
    logic       down_n;
    logic       left_n;
    logic       right_n;
    logic       start_n;
    logic [7:0] row_occ;
    logic       lane_step;
    logic [2:0] frog_row;
    logic [7:0] frog_col;
    logic       frog_visible;
    logic [2:0] lives;
    logic [7:0] score;
    logic [2:0] state;
`ifdef FROGGER_TIMER_EN
    logic [7:0] time_left;
`endif

    // Controller side
    modport master (
        input  up_n, down_n, left_n, right_n, start_n, row_occ,
        output lane_step, frog_row, frog_col, frog_visible, lives, score, state
`ifdef FROGGER_TIMER_EN
        , output time_left
`endif
    );

    // Board / datapath / display side
    modport slave (
        output up_n, down_n, left_n, right_n, start_n, row_occ,
        input  lane_step, frog_row, frog_col, frog_visible, lives, score, state
`ifdef FROGGER_TIMER_EN
        , input time_left
`endif
    );
endinterface
`default_nettype wire

// File: rtl/frogger_game_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : frogger_game_ctrl
//  Description : Frogger round sequencer: button debounce, frog moves,
//                lane-advance tick, collision detection, lives/score and the
//                IDLE/PLAY/DEAD/WIN/OVER state machine.
//                Optional macro FROGGER_TIMER_EN adds a per-round countdown.
//  Revision    : 1.0 - initial release
// ============================================================================
module frogger_game_ctrl #(
    parameter int TICK_DIV    = 100000000,
    parameter int DEBOUNCE    = 1000000,
    parameter int LIVES       = 3,
    parameter int FLASH_TICKS = 2
`ifdef FROGGER_TIMER_EN
    , parameter int ROUND_TICKS = 30
`endif
) (
    input  wire logic           clk,
    input  wire logic           reset,
    frogger_game_ctrl_if.master bus
);
    localparam int TW  = $clog2(TICK_DIV);
    localparam int DBW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam int FW  = $clog2(2 * FLASH_TICKS);

    localparam logic [TW-1:0]  C_TICK_MAX  = TW'(TICK_DIV - 1);
    localparam logic [DBW-1:0] C_DB_MAX    = DBW'(DEBOUNCE - 1);
    localparam logic [FW-1:0]  C_FLASH_MAX = FW'(2 * FLASH_TICKS - 1);
    localparam logic [2:0]     C_LIVES     = 3'(LIVES);
    localparam logic [2:0]     C_HOME_ROW  = 3'd7;
    localparam logic [7:0]     C_HOME_COL  = 8'b0001_0000;

    localparam int C_BTN_UP    = 0;
    localparam int C_BTN_DOWN  = 1;
    localparam int C_BTN_LEFT  = 2;
    localparam int C_BTN_RIGHT = 3;
    localparam int C_BTN_START = 4;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PLAY = 3'd1;
    localparam logic [2:0] S_DEAD = 3'd2;
    localparam logic [2:0] S_WIN  = 3'd3;
    localparam logic [2:0] S_OVER = 3'd4;

    logic [4:0]    w_btn_n;
    logic [4:0]    w_press;
    logic [TW-1:0] r_tick_cnt;
    logic          w_tick;
    logic          r_lane_step;
    logic [2:0]    r_state, w_state_nxt;
    logic [2:0]    r_frog_row, w_row_nxt;
    logic [7:0]    r_frog_col, w_col_nxt;
    logic          r_vis, w_vis_nxt;
    logic [2:0]    r_lives, w_lives_nxt;
    logic [7:0]    r_score, w_score_nxt;
    logic [FW-1:0] r_flash_cnt, w_flash_nxt;
    logic          w_danger, w_hit, w_expire, w_fail, w_last_flash;

    assign w_btn_n = {bus.start_n, bus.right_n, bus.left_n, bus.down_n, bus.up_n};

    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_btn
            logic           r_sync1, r_sync2, r_level, r_press;
            logic [DBW-1:0] r_cnt;
            // Synchronise, require a stable changed level, pulse on the debounced press edge
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_sync1 <= 1'b1;
                    r_sync2 <= 1'b1;
                    r_level <= 1'b1;
                    r_cnt   <= '0;
                    r_press <= 1'b0;
                end else begin
                    r_sync1 <= w_btn_n[gi];
                    r_sync2 <= r_sync1;
                    r_press <= 1'b0;
                    if (r_sync2 == r_level) begin
                        r_cnt <= '0;
                    end else if (r_cnt == C_DB_MAX) begin
                        r_cnt   <= '0;
                        r_level <= r_sync2;
                        r_press <= ~r_sync2;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end
            assign w_press[gi] = r_press;
        end
    endgenerate

    assign w_tick = (r_tick_cnt == C_TICK_MAX);

    // Free-running tick divider; lane advance only reaches the datapath during play
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tick_cnt  <= '0;
            r_lane_step <= 1'b0;
        end else begin
            r_tick_cnt  <= w_tick ? '0 : r_tick_cnt + 1'b1;
            r_lane_step <= w_tick && (r_state == S_PLAY);
        end
    end

    // Rows 0 (goal), 4 (median) and 7 (start) carry no cars
    assign w_danger     = (r_frog_row != 3'd0) && (r_frog_row != 3'd4) && (r_frog_row != 3'd7);
    assign w_hit        = w_danger && ((bus.row_occ & r_frog_col) != 8'h00);
    assign w_fail       = w_hit || w_expire;
    assign w_last_flash = w_tick && (r_flash_cnt == C_FLASH_MAX);

`ifdef FROGGER_TIMER_EN
    logic [7:0] r_time_left;
    // Round countdown: reload on every entry to play, count down on lane steps
    always_ff @(posedge clk) begin
        if (reset) begin
            r_time_left <= '0;
        end else if ((w_state_nxt == S_PLAY) && (r_state != S_PLAY)) begin
            r_time_left <= 8'(ROUND_TICKS);
        end else if ((r_state == S_PLAY) && r_lane_step && (r_time_left != 8'd0)) begin
            r_time_left <= r_time_left - 8'd1;
        end
    end
    assign w_expire      = (r_state == S_PLAY) && (r_time_left == 8'd0);
    assign bus.time_left = r_time_left;
`else
    assign w_expire = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_OVER: if (w_press[C_BTN_START]) w_state_nxt = S_PLAY;
            S_PLAY: begin
                if (w_fail)                   w_state_nxt = S_DEAD;
                else if (r_frog_row == 3'd0)  w_state_nxt = S_WIN;
            end
            S_DEAD: if (w_last_flash) w_state_nxt = (r_lives == 3'd0) ? S_OVER : S_PLAY;
            S_WIN:  if (w_last_flash) w_state_nxt = S_PLAY;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output decode: next frog position, visibility, lives, score and flash count
    always_comb begin
        w_row_nxt   = r_frog_row;
        w_col_nxt   = r_frog_col;
        w_vis_nxt   = r_vis;
        w_lives_nxt = r_lives;
        w_score_nxt = r_score;
        w_flash_nxt = r_flash_cnt;
        case (r_state)
            S_IDLE, S_OVER: begin
                if (w_press[C_BTN_START]) begin
                    w_lives_nxt = C_LIVES;
                    w_score_nxt = 8'd0;
                    w_row_nxt   = C_HOME_ROW;
                    w_col_nxt   = C_HOME_COL;
                    w_vis_nxt   = 1'b1;
                end
            end
            S_PLAY: begin
                // Collision beats a win check, which beats any move this cycle
                if (w_fail) begin
                    w_lives_nxt = (r_lives == 3'd0) ? 3'd0 : r_lives - 3'd1;
                    w_flash_nxt = '0;
                end else if (r_frog_row == 3'd0) begin
                    w_score_nxt = (r_score == 8'hFF) ? r_score : r_score + 8'd1;
                    w_flash_nxt = '0;
                end else if (w_press[C_BTN_UP]) begin
                    w_row_nxt = r_frog_row - 3'd1;
                end else if (w_press[C_BTN_DOWN]) begin
                    if (r_frog_row != 3'd7) w_row_nxt = r_frog_row + 3'd1;
                end else if (w_press[C_BTN_LEFT]) begin
                    if (!r_frog_col[7]) w_col_nxt = r_frog_col << 1;
                end else if (w_press[C_BTN_RIGHT]) begin
                    if (!r_frog_col[0]) w_col_nxt = r_frog_col >> 1;
                end
            end
            S_DEAD, S_WIN: begin
                if (w_tick) begin
                    if (r_flash_cnt == C_FLASH_MAX) begin
                        w_row_nxt   = C_HOME_ROW;
                        w_col_nxt   = C_HOME_COL;
                        w_vis_nxt   = (w_state_nxt != S_OVER);
                        w_flash_nxt = '0;
                    end else begin
                        w_vis_nxt   = ~r_vis;
                        w_flash_nxt = r_flash_cnt + 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // Game datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_frog_row  <= C_HOME_ROW;
            r_frog_col  <= C_HOME_COL;
            r_vis       <= 1'b1;
            r_lives     <= C_LIVES;
            r_score     <= 8'd0;
            r_flash_cnt <= '0;
        end else begin
            r_frog_row  <= w_row_nxt;
            r_frog_col  <= w_col_nxt;
            r_vis       <= w_vis_nxt;
            r_lives     <= w_lives_nxt;
            r_score     <= w_score_nxt;
            r_flash_cnt <= w_flash_nxt;
        end
    end

    assign bus.lane_step    = r_lane_step;
    assign bus.frog_row     = r_frog_row;
    assign bus.frog_col     = r_frog_col;
    assign bus.frog_visible = r_vis;
    assign bus.lives        = r_lives;
    assign bus.score        = r_score;
    assign bus.state        = r_state;

endmodule
`default_nettype wire

// File: tb/tb_frogger_game_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_frogger_game_ctrl
//  Description : Directed, table-driven bench for frogger_game_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_frogger_game_ctrl;
    localparam int TICK_DIV    = 4;
    localparam int DEBOUNCE    = 2;
    localparam int LIVES       = 3;
    localparam int FLASH_TICKS = 1;

    localparam logic [4:0] B_NONE = 5'b00000;
    localparam logic [4:0] B_UP   = 5'b00001;
    localparam logic [4:0] B_DN   = 5'b00010;
    localparam logic [4:0] B_LT   = 5'b00100;
    localparam logic [4:0] B_RT   = 5'b01000;
    localparam logic [4:0] B_ST   = 5'b10000;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PLAY = 3'd1;
    localparam logic [2:0] S_DEAD = 3'd2;
    localparam logic [2:0] S_WIN  = 3'd3;
    localparam logic [2:0] S_OVER = 3'd4;

    logic clk = 1'b0;
    logic reset;

    frogger_game_ctrl_if bus();

    frogger_game_ctrl #(
        .TICK_DIV    (TICK_DIV),
        .DEBOUNCE    (DEBOUNCE),
        .LIVES       (LIVES),
        .FLASH_TICKS (FLASH_TICKS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] btn;
        logic [7:0] occ;
        logic [2:0] row;
        logic [7:0] col;
        logic [2:0] st;
    } vec_t;

    vec_t vecs [0:14];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        else             n_pass++;
    endtask

    task automatic drive_btn(input logic [4:0] m);
        bus.up_n    = ~m[0];
        bus.down_n  = ~m[1];
        bus.left_n  = ~m[2];
        bus.right_n = ~m[3];
        bus.start_n = ~m[4];
    endtask

    task automatic press(input logic [4:0] m);
        drive_btn(m);
        repeat (6) @(negedge clk);
        drive_btn(B_NONE);
        repeat (6) @(negedge clk);
    endtask

    task automatic wait_state(input logic [2:0] exp, input int budget, input string name);
        int k = 0;
        while (bus.state !== exp && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(name, bus.state, exp);
    endtask

    task automatic run_vecs(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            bus.row_occ = vecs[i].occ;
            press(vecs[i].btn);
            chk($sformatf("vec%0d_row", i), bus.frog_row, vecs[i].row);
            chk($sformatf("vec%0d_col", i), bus.frog_col, vecs[i].col);
            chk($sformatf("vec%0d_state", i), bus.state, vecs[i].st);
        end
    endtask

    task automatic die(input string name);
        int k = 0;
        bus.row_occ = 8'h10;
        drive_btn(B_UP);
        wait_state(S_DEAD, 15, {name, "_enter"});
        drive_btn(B_NONE);
        while (bus.state == S_DEAD && k < 40) begin
            @(negedge clk);
            k++;
        end
        bus.row_occ = 8'h00;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_state"}, bus.state, S_IDLE);
        chk({tag, "_row"},   bus.frog_row, 3'd7);
        chk({tag, "_col"},   bus.frog_col, 8'h10);
        chk({tag, "_vis"},   bus.frog_visible, 1'b1);
        chk({tag, "_lives"}, bus.lives, 3'd3);
        chk({tag, "_score"}, bus.score, 8'd0);
        chk({tag, "_lane"},  bus.lane_step, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int ones, trans, k, gap, changes, zeros;
        logic [2:0] prev_st;
        logic [7:0] prev_col;

        vecs[0]  = '{B_LT,        8'h00, 3'd7, 8'h20, S_PLAY};
        vecs[1]  = '{B_LT,        8'h00, 3'd7, 8'h40, S_PLAY};
        vecs[2]  = '{B_LT,        8'h00, 3'd7, 8'h80, S_PLAY};
        vecs[3]  = '{B_LT,        8'h00, 3'd7, 8'h80, S_PLAY};
        vecs[4]  = '{B_UP | B_LT, 8'h00, 3'd6, 8'h40, S_PLAY};
        vecs[5]  = '{B_DN,        8'h00, 3'd7, 8'h40, S_PLAY};
        vecs[6]  = '{B_RT,        8'h00, 3'd7, 8'h20, S_PLAY};
        vecs[7]  = '{B_RT,        8'h00, 3'd7, 8'h10, S_PLAY};
        vecs[8]  = '{B_DN,        8'h00, 3'd7, 8'h10, S_PLAY};
        vecs[9]  = '{B_UP,        8'h00, 3'd6, 8'h10, S_PLAY};
        vecs[10] = '{B_UP,        8'h00, 3'd5, 8'h10, S_PLAY};
        vecs[11] = '{B_UP,        8'h00, 3'd4, 8'h10, S_PLAY};
        vecs[12] = '{B_UP,        8'h00, 3'd3, 8'h10, S_PLAY};
        vecs[13] = '{B_UP,        8'h00, 3'd2, 8'h10, S_PLAY};
        vecs[14] = '{B_UP,        8'h00, 3'd1, 8'h10, S_PLAY};

        // Reset and idle with buttons released
        drive_btn(B_NONE);
        bus.row_occ = 8'h00;
        reset = 1'b1;
        ones = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.lane_step) ones++;
        end
        chk_reset_vals("rst");
        reset = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (bus.lane_step) ones++;
        end
        chk("idle_lane_step_ones", ones, 0);
        chk("idle_state", bus.state, S_IDLE);

        // Long start press gives exactly one entry to PLAY
        trans = 0;
        prev_st = bus.state;
        drive_btn(B_ST);
        repeat (10) begin
            @(negedge clk);
            if (prev_st == S_IDLE && bus.state == S_PLAY) trans++;
            prev_st = bus.state;
        end
        drive_btn(B_NONE);
        repeat (10) begin
            @(negedge clk);
            if (prev_st == S_IDLE && bus.state == S_PLAY) trans++;
            prev_st = bus.state;
        end
        chk("start_transitions", trans, 1);
        chk("start_state", bus.state, S_PLAY);
        chk("start_lives", bus.lives, 3'd3);

        // lane_step period in PLAY
        k = 0;
        while (!bus.lane_step && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk("lane_step_seen", bus.lane_step, 1'b1);
        for (int g = 0; g < 3; g++) begin
            gap = 0;
            do begin
                @(negedge clk);
                gap++;
            end while (!bus.lane_step && gap < 10);
            chk($sformatf("lane_gap%0d", g), gap, 4);
        end

        // Left moves including the blocked edge
        run_vecs(0, 3);

        // Held right button moves exactly once
        changes = 0;
        prev_col = bus.frog_col;
        drive_btn(B_RT);
        repeat (20) begin
            @(negedge clk);
            if (bus.frog_col != prev_col) changes++;
            prev_col = bus.frog_col;
        end
        drive_btn(B_NONE);
        repeat (10) begin
            @(negedge clk);
            if (bus.frog_col != prev_col) changes++;
            prev_col = bus.frog_col;
        end
        chk("hold_right_moves", changes, 1);
        chk("hold_right_col", bus.frog_col, 8'h40);

        // Simultaneous up+left, down/right, blocked down at row 7
        run_vecs(4, 8);

        // Collision on row 6: DEAD the very next cycle, then flash and respawn
        bus.row_occ = 8'h10;
        drive_btn(B_UP);
        k = 0;
        while (bus.frog_row != 3'd6 && k < 12) begin
            @(negedge clk);
            k++;
        end
        chk("hit_row6", bus.frog_row, 3'd6);
        @(negedge clk);
        chk("hit_state_dead", bus.state, S_DEAD);
        chk("hit_lives", bus.lives, 3'd2);
        drive_btn(B_NONE);
        bus.row_occ = 8'h00;
        k = 0;
        zeros = 0;
        while (bus.state == S_DEAD && k < 40) begin
            @(negedge clk);
            k++;
            if (bus.state == S_DEAD && !bus.frog_visible) zeros++;
        end
        chk("dead_vis_low_cycles", zeros, 4);
        chk("respawn_state", bus.state, S_PLAY);
        chk("respawn_vis", bus.frog_visible, 1'b1);
        chk("respawn_row", bus.frog_row, 3'd7);
        chk("respawn_col", bus.frog_col, 8'h10);

        // Crossing to the goal
        run_vecs(9, 14);
        drive_btn(B_UP);
        wait_state(S_WIN, 12, "win_enter");
        chk("win_score", bus.score, 8'd1);
        chk("win_row", bus.frog_row, 3'd0);
        drive_btn(B_NONE);
        wait_state(S_PLAY, 20, "win_to_play");
        chk("win_home_row", bus.frog_row, 3'd7);
        chk("win_home_col", bus.frog_col, 8'h10);
        chk("win_home_vis", bus.frog_visible, 1'b1);

        // Remaining lives run out
        die("death2");
        chk("death2_state", bus.state, S_PLAY);
        chk("death2_lives", bus.lives, 3'd1);
        die("death3");
        chk("over_state", bus.state, S_OVER);
        chk("over_lives", bus.lives, 3'd0);
        chk("over_vis", bus.frog_visible, 1'b0);
        press(B_LT);
        chk("over_move_ignored", bus.state, S_OVER);

        // Restart from OVER
        press(B_ST);
        chk("restart_state", bus.state, S_PLAY);
        chk("restart_lives", bus.lives, 3'd3);
        chk("restart_score", bus.score, 8'd0);
        chk("restart_vis", bus.frog_visible, 1'b1);
        chk("restart_col", bus.frog_col, 8'h10);

        // Reset while flashing after a death
        bus.row_occ = 8'h10;
        drive_btn(B_UP);
        wait_state(S_DEAD, 15, "midflash_enter");
        drive_btn(B_NONE);
        k = 0;
        while (bus.frog_visible && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk("midflash_vis_low", bus.frog_visible, 1'b0);
        bus.row_occ = 8'h00;
        reset = 1'b1;
        @(negedge clk);
        chk_reset_vals("midrst");
        reset = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/frogger_game_ctrl.md
Name: frogger_game_ctrl

Overview:
- Game-sequencing controller for the 8x8 Frogger playfield.
- Debounces the active-low push buttons and turns each press into exactly one frog move.
- Generates the lane-advance tick for the car-row datapath and detects collisions against that datapath's occupancy bits.
- Owns lives, score and the round state machine that the VGA draw logic reads.

Parameters:
- TICK_DIV, 100000000, clk cycles per lane_step pulse (min 2).
- DEBOUNCE, 1000000, cycles a synchronized button must be stable before it is accepted (min 1).
- LIVES, 3, lives loaded at game start (1..7).
- FLASH_TICKS, 2, on/off flash pairs shown after death or win.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- up_n, down_n, left_n, right_n, start_n  in  1 each  raw buttons, active-low, asynchronous.
- row_occ  in  8  car occupancy of row frog_row, combinational from datapath; bit7 = leftmost column.
- lane_step  out  1  one-cycle pulse; datapath shifts cars by one.
- frog_row  out  3  0 = goal (top), 7 = start (bottom).
- frog_col  out  8  one-hot column, bit7 = leftmost.
- frog_visible  out  1  frog drawn when 1.
- lives  out  3  remaining lives.
- score  out  8  crossings completed.
- state  out  3  IDLE=0, PLAY=1, DEAD=2, WIN=3, OVER=4.

Behaviour:
- Reset values: state=IDLE, frog_row=7, frog_col=8'b0001_0000, frog_visible=1, lives=LIVES, score=0, lane_step=0; tick, flash and debounce counters 0; debounced button level 1 (released).
- Button input path (per button):
  - 2-FF synchronizer, then a stability counter.
  - Debounced level updates only after DEBOUNCE consecutive cycles of a changed synchronized value.
  - Press pulse = one cycle on the debounced 1->0 edge. Holding a button gives one pulse; no auto-repeat.
- Tick counter:
  - Free-runs 0..TICK_DIV-1 in every state and wraps to 0.
  - The wrap cycle is tick.
  - lane_step = tick registered, gated to state==PLAY. Tick continues in other states to time flashing.
- IDLE / OVER: start press -> lives=LIVES, score=0, frog home (row 7, col 8'b0001_0000), frog_visible=1, go to PLAY. Move presses are ignored.
- PLAY, moves (one per cycle):
  - Priority up > down > left > right; lower-priority simultaneous pulses are dropped.
  - up: row-1 unless row==0. down: row+1 unless row==7.
  - left: col<<1 unless col[7]. right: col>>1 unless col[0]. Blocked moves are a no-op.
- PLAY, collision:
  - Condition: (row_occ & frog_col)!=0 while frog_row is in {1,2,3,5,6}. Rows 0, 4 and 7 are safe.
  - Evaluated on the registered position. Collision has priority over a move in the same cycle (move dropped).
  - Next state DEAD; lives decrements on entry (saturates at 0); flash counter cleared.
- PLAY, win:
  - Condition: frog_row==0.
  - Next state WIN; score+1, saturating at 255.
- DEAD / WIN:
  - frog_visible toggles on each tick, for 2*FLASH_TICKS ticks.
  - On the final tick, frog_visible=1 and the frog returns home.
  - DEAD goes to OVER if lives==0, otherwise PLAY. WIN goes to PLAY.
  - Buttons are ignored during these states.
- OVER: frog_visible=0.
- Reset mid-operation returns everything to reset values on the next edge, regardless of state.

Optional Feature:
- Macro: FROGGER_TIMER_EN.
- When defined:
  - Adds parameter ROUND_TICKS (default 30) and output time_left [7:0].
  - time_left loads ROUND_TICKS on every entry to PLAY from IDLE, OVER, DEAD or WIN, and decrements on each lane_step.
  - When time_left==0 while in PLAY, treat it as a collision: enter DEAD, lives-1.
  - A collision and an expiry in the same cycle decrement lives once.
- When undefined: no time_left port and no timeout; behaviour is exactly as above.

Test Plan:
Bench parameters: TICK_DIV=4, DEBOUNCE=2, LIVES=3, FLASH_TICKS=1.
- Reset, hold all buttons high -> state=0, frog_row=7, frog_col=0x10, lives=3, score=0, lane_step never 1.
- start_n low for 10 cycles then high -> exactly one transition to PLAY. In PLAY, lane_step pulses once every 4 cycles.
- In PLAY, press left 4x (row_occ=0) -> frog_col 0x20, 0x40, 0x80, 0x80. Hold right_n low 20 cycles -> exactly one move, to 0x40. Press up and left in the same cycle -> only the row changes.
- Move to row 6 with row_occ=0x10 and frog_col=0x10 -> DEAD next cycle, lives=2. frog_visible toggles 0 then 1 over 2 ticks, then PLAY with frog at row 7, col 0x10.
- Step up 7x with row_occ=0 -> WIN, score=1, then PLAY at home. Three deaths -> OVER with lives=0 and frog_visible=0; start -> PLAY with lives=3, score=0.
- Assert reset while in DEAD mid-flash -> all outputs at reset values next cycle.
